// File: rtl/spi_mem_prog_seq_pkg.sv
// Shared opcodes, expected device ID and state encodings for the SPI flash
// page-programming sequencer.
`timescale 1ns/1ps
package spi_mem_prog_seq_pkg;

    localparam logic [7:0] CMD_RDID   = 8'h9F;
    localparam logic [7:0] CMD_WRVECR = 8'h61;
    localparam logic [7:0] CMD_WREN   = 8'h06;
    localparam logic [7:0] CMD_PP     = 8'h02;
    localparam logic [7:0] CMD_SE     = 8'hD8;
    localparam logic [7:0] CMD_RDSR   = 8'h05;
    localparam logic [7:0] JEDEC_ID   = 8'h20;

    // Enhanced volatile config: quad protocol on, dual off, hold/reset disabled
    localparam logic [7:0] VECR_QUAD  = 8'b010_01_111;

    typedef enum logic [3:0] {
        IDLE, RDID, VECR, WREN_E, ERASE, POLL_E, LOAD,
        WREN_P, PROG, POLL_P, NEXT, DONE, FAIL
    } state_t;

    typedef enum logic [1:0] {PH_ISSUE, PH_SKIP, PH_WAIT} phase_t;

    typedef enum logic [1:0] {FC_NONE, FC_ID, FC_CTRL, FC_TIMEOUT} fail_code_t;

endpackage

// File: rtl/page_assembler.sv
// Collects one page of streamed bytes; the first byte lands in the top byte
// of the payload so the payload can follow the address MSB-first.
`timescale 1ns/1ps
module page_assembler #(
    parameter int PAGE_BYTES = 256
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_en,
    input  logic [7:0]              s_data,
    input  logic                    take,
    output logic [PAGE_BYTES*8-1:0] payload,
    output logic                    full
);

    localparam int CW = $clog2(PAGE_BYTES + 1);

    logic [CW-1:0] cnt;

    assign full = (cnt == CW'(PAGE_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!load_en)
            cnt <= '0;
        else if (take)
            cnt <= cnt + 1'b1;
    end

    generate
        if (PAGE_BYTES == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    payload <= '0;
                else if (load_en && take)
                    payload <= s_data;
            end
        end else begin : g_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    payload <= '0;
                else if (load_en && take)
                    payload <= {payload[PAGE_BYTES*8-9:0], s_data};
            end
        end
    endgenerate

endmodule

// File: rtl/spi_mem_prog_seq.sv
// Drives a QSPI memory controller through ID check, optional quad switch,
// sector erase and page programming of NUM_PAGES streamed pages.
`timescale 1ns/1ps
module spi_mem_prog_seq
    import spi_mem_prog_seq_pkg::*;
#(
    parameter int          PAGE_BYTES = 256,
    parameter int          NUM_PAGES  = 4,
    parameter logic [23:0] BASE_ADDR  = 24'hA30000,
    parameter bit          ERASE_EN   = 1'b1,
    parameter bit          USE_QUAD   = 1'b1,
    parameter int          POLL_LIMIT = 2000000
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          mc_trigger,
    output logic                          mc_quad_mode,
    output logic [7:0]                    mc_cmd,
    output logic [(3+PAGE_BYTES)*8-1:0]   mc_data_send,
    input  logic [7:0]                    mc_readout,
    input  logic                          mc_busy,
    input  logic                          mc_error,
    output logic                          done,
    output logic                          fail,
    output logic [1:0]                    fail_code,
    output logic [15:0]                   pages_done
);

    localparam int DW = (3 + PAGE_BYTES) * 8;
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

    state_t                  state, state_n;
    phase_t                  ph, ph_n;
    logic [23:0]             addr, addr_n, addr_inc;
    logic [PW-1:0]           poll_cnt, poll_n;
    logic [PAGE_BYTES*8-1:0] payload;
    logic                    full, take;
    logic [7:0]              op;
    logic [DW-1:0]           op_data;
    logic                    trig_n, quad_n, done_n, fail_n;
    logic [7:0]              cmd_n;
    logic [DW-1:0]           dsend_n;
    logic [1:0]              code_n;
    logic [15:0]             pd_n;

    assign s_ready  = (state == LOAD) && !full;
    assign take     = s_valid && s_ready;
    assign addr_inc = addr + 24'(PAGE_BYTES);

    page_assembler #(.PAGE_BYTES(PAGE_BYTES)) u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (state == LOAD),
        .s_data  (s_data),
        .take    (take),
        .payload (payload),
        .full    (full)
    );

    // Opcode and argument image for whichever command state we are in
    always_comb begin
        op      = 8'h00;
        op_data = '0;
        case (state)
            RDID:           op = CMD_RDID;
            VECR: begin
                op           = CMD_WRVECR;
                op_data[7:0] = VECR_QUAD;
            end
            WREN_E, WREN_P: op = CMD_WREN;
            ERASE: begin
                op                  = CMD_SE;
                op_data[DW-1 -: 24] = addr;
            end
            POLL_E, POLL_P: op = CMD_RDSR;
            PROG: begin
                op      = CMD_PP;
                op_data = {addr, payload};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        ph_n    = ph;
        trig_n  = 1'b0;
        cmd_n   = mc_cmd;
        dsend_n = mc_data_send;
        quad_n  = mc_quad_mode;
        done_n  = done;
        fail_n  = fail;
        code_n  = fail_code;
        pd_n    = pages_done;
        addr_n  = addr;
        poll_n  = poll_cnt;
        case (state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    state_n = RDID;
                    ph_n    = PH_ISSUE;
                    quad_n  = 1'b0;
                    done_n  = 1'b0;
                    fail_n  = 1'b0;
                    code_n  = FC_NONE;
                    pd_n    = '0;
                    addr_n  = BASE_ADDR;
                    poll_n  = '0;
                end
            end
            LOAD: begin
                if (full) begin
                    state_n = WREN_P;
                    ph_n    = PH_ISSUE;
                end
            end
            NEXT: begin
                ph_n = PH_ISSUE;
                if (pages_done == 16'(NUM_PAGES)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    addr_n  = addr_inc;
                    // A wrap past the top of the array lands on a sector start too
                    state_n = (ERASE_EN && addr_inc[15:0] == 16'h0) ? WREN_E : LOAD;
                end
            end
            default: begin
                case (ph)
                    PH_ISSUE: begin
                        if (!mc_busy) begin
                            trig_n  = 1'b1;
                            cmd_n   = op;
                            dsend_n = op_data;
                            ph_n    = PH_SKIP;
                        end
                    end
                    // Controller raises busy one cycle after the trigger
                    PH_SKIP: ph_n = PH_WAIT;
                    PH_WAIT: begin
                        if (!mc_busy) begin
                            ph_n = PH_ISSUE;
                            if (mc_error) begin
                                state_n = FAIL;
                                fail_n  = 1'b1;
                                code_n  = FC_CTRL;
                            end else begin
                                case (state)
                                    RDID: begin
                                        if (mc_readout != JEDEC_ID) begin
                                            state_n = FAIL;
                                            fail_n  = 1'b1;
                                            code_n  = FC_ID;
                                        end else if (USE_QUAD) begin
                                            state_n = VECR;
                                        end else begin
                                            state_n = ERASE_EN ? WREN_E : LOAD;
                                        end
                                    end
                                    VECR: begin
                                        quad_n  = 1'b1;
                                        state_n = ERASE_EN ? WREN_E : LOAD;
                                    end
                                    WREN_E: state_n = ERASE;
                                    ERASE:  state_n = POLL_E;
                                    WREN_P: state_n = PROG;
                                    PROG:   state_n = POLL_P;
                                    POLL_E, POLL_P: begin
                                        if (!mc_readout[0]) begin
                                            poll_n = '0;
                                            if (state == POLL_E) begin
                                                state_n = LOAD;
                                            end else begin
                                                pd_n    = pages_done + 16'd1;
                                                state_n = NEXT;
                                            end
                                        end else if (poll_cnt >= POLL_LAST) begin
                                            state_n = FAIL;
                                            fail_n  = 1'b1;
                                            code_n  = FC_TIMEOUT;
                                        end else begin
                                            poll_n = poll_cnt + 1'b1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                    default: ph_n = PH_ISSUE;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ph           <= PH_ISSUE;
            mc_trigger   <= 1'b0;
            mc_cmd       <= 8'h00;
            mc_data_send <= '0;
            mc_quad_mode <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            fail_code    <= 2'd0;
            pages_done   <= 16'd0;
            addr         <= BASE_ADDR;
            poll_cnt     <= '0;
        end else begin
            state        <= state_n;
            ph           <= ph_n;
            mc_trigger   <= trig_n;
            mc_cmd       <= cmd_n;
            mc_data_send <= dsend_n;
            mc_quad_mode <= quad_n;
            done         <= done_n;
            fail         <= fail_n;
            fail_code    <= code_n;
            pages_done   <= pd_n;
            addr         <= addr_n;
            poll_cnt     <= poll_n;
        end
    end

endmodule

// File: tb/tb_spi_mem_prog_seq.sv
// Scoreboard bench: a behavioural flash/controller model answers commands,
// expected command trace and end status are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_spi_mem_prog_seq;

    localparam int          PB   = 256;
    localparam int          NP   = 2;
    localparam int          PL   = 16;
    localparam int          BUSY = 3;
    localparam logic [23:0] BASE = 24'hFFFF00;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [7:0]           s_data = 8'h00;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic                 mc_trigger, mc_quad_mode;
    logic [7:0]           mc_cmd;
    logic [(3+PB)*8-1:0]  mc_data_send;
    logic [7:0]           mc_readout;
    logic                 mc_busy, mc_error;
    logic                 done, fail;
    logic [1:0]           fail_code;
    logic [15:0]          pages_done;

    always #5 clk = ~clk;

    spi_mem_prog_seq #(
        .PAGE_BYTES(PB), .NUM_PAGES(NP), .BASE_ADDR(BASE),
        .ERASE_EN(1'b1), .USE_QUAD(1'b1), .POLL_LIMIT(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mc_trigger(mc_trigger), .mc_quad_mode(mc_quad_mode), .mc_cmd(mc_cmd),
        .mc_data_send(mc_data_send), .mc_readout(mc_readout),
        .mc_busy(mc_busy), .mc_error(mc_error),
        .done(done), .fail(fail), .fail_code(fail_code), .pages_done(pages_done)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        bit          chk_addr;
        bit          quad;
        bit          chk_d8;
    } exp_t;

    typedef struct {
        bit          dn;
        bit          fl;
        logic [1:0]  code;
        logic [15:0] pd;
    } st_t;

    exp_t exp_q[$];
    st_t  st_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   prev_end = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        st_t  s;
        if (rst_n && mc_trigger) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_trigger: cmd %0h issued, none expected (t=%0t)", mc_cmd, $time);
            end else begin
                e = exp_q.pop_front();
                chk("cmd", {24'h0, mc_cmd}, {24'h0, e.cmd});
                chk("quad_at_trigger", {31'h0, mc_quad_mode}, {31'h0, e.quad});
                chk("busy_at_trigger", {31'h0, mc_busy}, 32'h0);
                if (e.chk_addr)
                    chk("addr", {8'h0, mc_data_send[(3+PB)*8-1 -: 24]}, {8'h0, e.addr});
                if (e.chk_d8)
                    chk("vecr_data", {24'h0, mc_data_send[7:0]}, 32'h4F);
            end
        end
        if (rst_n && (done || fail) && !prev_end) begin
            if (st_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_end: done=%0b fail=%0b code=%0d", done, fail, fail_code);
            end else begin
                s = st_q.pop_front();
                chk("done", {31'h0, done}, {31'h0, s.dn});
                chk("fail", {31'h0, fail}, {31'h0, s.fl});
                chk("fail_code", {30'h0, fail_code}, {30'h0, s.code});
                chk("pages_done", {16'h0, pages_done}, {16'h0, s.pd});
            end
        end
        prev_end = rst_n && (done || fail);
    end

    // ---------------- flash + controller model ----------------
    logic [7:0] mem [int];
    logic [7:0] id_val = 8'h20;
    bit         hold_wip = 1'b0;
    bit         err_on_pp = 1'b0;
    bit         wel;
    int         wip_left;
    int         busy_cnt;
    logic [7:0] rd_pend;
    bit         err_pend;

    function automatic int key(input logic [23:0] a);
        return int'({8'h0, a});
    endfunction

    function automatic logic [7:0] rd(input logic [23:0] a);
        return mem.exists(key(a)) ? mem[key(a)] : 8'hFF;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [23:0] a;
        if (!rst_n) begin
            mc_busy    <= 1'b0;
            mc_error   <= 1'b0;
            mc_readout <= 8'h00;
            busy_cnt   = 0;
            wel        = 1'b0;
            wip_left   = 0;
        end else if (mc_trigger) begin
            mc_busy  <= 1'b1;
            mc_error <= 1'b0;
            busy_cnt = BUSY;
            err_pend = 1'b0;
            rd_pend  = 8'h00;
            a = mc_data_send[(3+PB)*8-1 -: 24];
            case (mc_cmd)
                8'h9F: rd_pend = id_val;
                8'h06: wel = 1'b1;
                8'hD8: if (wel) begin
                    for (int k = 0; k < 65536; k++)
                        if (mem.exists(key({a[23:16], 16'(k)}))) mem.delete(key({a[23:16], 16'(k)}));
                    wel = 1'b0;
                    wip_left = 2;
                end
                8'h02: if (wel) begin
                    for (int k = 0; k < PB; k++)
                        mem[key(a + 24'(k))] = mc_data_send[(PB-k)*8-1 -: 8];
                    wel = 1'b0;
                    wip_left = 2;
                    err_pend = err_on_pp;
                end
                8'h05: begin
                    rd_pend = {7'd0, (hold_wip || wip_left > 0)};
                    if (wip_left > 0) wip_left--;
                end
                default: ;
            endcase
        end else if (mc_busy) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                mc_busy    <= 1'b0;
                mc_readout <= rd_pend;
                mc_error   <= err_pend;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] pat(input int i);
        logic [7:0] b;
        b = i[7:0];
        return (i >= 256) ? (b ^ 8'hA5) : b;
    endfunction

    task automatic pe(input logic [7:0] c, input logic [23:0] a, input bit ca, input bit q, input bit d8);
        exp_t e;
        e.cmd = c; e.addr = a; e.chk_addr = ca; e.quad = q; e.chk_d8 = d8;
        exp_q.push_back(e);
    endtask

    task automatic pst(input bit dn, input bit fl, input logic [1:0] c, input logic [15:0] pd);
        st_t s;
        s.dn = dn; s.fl = fl; s.code = c; s.pd = pd;
        st_q.push_back(s);
    endtask

    task automatic exp_head();
        pe(8'h9F, 24'h0, 1'b0, 1'b0, 1'b0);
        pe(8'h61, 24'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic exp_poll(input int n);
        for (int i = 0; i < n; i++) pe(8'h05, 24'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic exp_erase(input logic [23:0] a);
        pe(8'h06, 24'h0, 1'b0, 1'b1, 1'b0);
        pe(8'hD8, a, 1'b1, 1'b1, 1'b0);
        exp_poll(3);
    endtask

    task automatic exp_prog(input logic [23:0] a);
        pe(8'h06, 24'h0, 1'b0, 1'b1, 1'b0);
        pe(8'h02, a, 1'b1, 1'b1, 1'b0);
        exp_poll(3);
    endtask

    task automatic exp_full_run();
        exp_head();
        exp_erase(24'hFFFF00);
        exp_prog(24'hFFFF00);
        exp_erase(24'h000000);
        exp_prog(24'h000000);
        pst(1'b1, 1'b0, 2'd0, 16'd2);
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_bytes(input int base, input int n, input bit thr);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < n && cyc < 20000) begin
            @(negedge clk);
            s_data  = pat(base + i);
            s_valid = thr ? (cyc % 3 == 0) : 1'b1;
            #1 acc = s_valid && s_ready;
            @(posedge clk);
            if (acc) i++;
            cyc++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        chk("bytes_accepted", i, n);
    endtask

    task automatic wait_end(input string nm);
        int c = 0;
        while (!(done || fail) && c < 20000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 20000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no done/fail within %0d cycles", nm, c);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_trigger"}, {31'h0, mc_trigger}, 32'h0);
        chk({nm, "_quad"}, {31'h0, mc_quad_mode}, 32'h0);
        chk({nm, "_cmd"}, {24'h0, mc_cmd}, 32'h0);
        chk({nm, "_dsend_any"}, {31'h0, |mc_data_send}, 32'h0);
        chk({nm, "_s_ready"}, {31'h0, s_ready}, 32'h0);
        chk({nm, "_done"}, {31'h0, done}, 32'h0);
        chk({nm, "_fail"}, {31'h0, fail}, 32'h0);
        chk({nm, "_code"}, {30'h0, fail_code}, 32'h0);
        chk({nm, "_pages"}, {16'h0, pages_done}, 32'h0);
    endtask

    task automatic preload();
        mem.delete();
        mem[key(24'hFF0010)] = 8'h00;
        mem[key(24'h000110)] = 8'h11;
        mem[key(24'h010000)] = 8'h22;
    endtask

    task automatic check_mem(input string nm);
        int bad;
        for (int p = 0; p < 2; p++) begin
            logic [23:0] a;
            a = (p == 0) ? 24'hFFFF00 : 24'h000000;
            bad = 0;
            for (int k = 0; k < PB; k++)
                if (rd(a + 24'(k)) !== pat(p * PB + k)) bad++;
            chk($sformatf("%s_page%0d_bad_bytes", nm, p), bad, 0);
        end
        chk({nm, "_erased_ff0010"}, {24'h0, rd(24'hFF0010)}, 32'hFF);
        chk({nm, "_erased_000110"}, {24'h0, rd(24'h000110)}, 32'hFF);
        chk({nm, "_kept_010000"}, {24'h0, rd(24'h010000)}, 32'h22);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int c;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // wrong device ID: stop after RDID, nothing else may be issued
        id_val = 8'h00;
        pe(8'h9F, 24'h0, 1'b0, 1'b0, 1'b0);
        pst(1'b0, 1'b1, 2'd1, 16'd0);
        do_start();
        wait_end("bad_id");
        repeat (20) @(negedge clk);
        id_val = 8'h20;

        // two pages across the top-of-array wrap, free-running stream
        preload();
        exp_full_run();
        do_start();
        send_bytes(0, 2 * PB, 1'b0);
        wait_end("wrap_run");
        check_mem("wrap_run");

        // same run with the stream throttled to one byte in three cycles
        preload();
        exp_full_run();
        do_start();
        send_bytes(0, 2 * PB, 1'b1);
        wait_end("throttled");
        check_mem("throttled");

        // device never leaves WIP: exactly PL status reads then timeout
        hold_wip = 1'b1;
        exp_head();
        pe(8'h06, 24'h0, 1'b0, 1'b1, 1'b0);
        pe(8'hD8, 24'hFFFF00, 1'b1, 1'b1, 1'b0);
        exp_poll(PL);
        pst(1'b0, 1'b1, 2'd3, 16'd0);
        do_start();
        wait_end("poll_timeout");
        repeat (30) @(negedge clk);
        hold_wip = 1'b0;

        // controller error reported on the page program
        err_on_pp = 1'b1;
        exp_head();
        exp_erase(24'hFFFF00);
        pe(8'h06, 24'h0, 1'b0, 1'b1, 1'b0);
        pe(8'h02, 24'hFFFF00, 1'b1, 1'b1, 1'b0);
        pst(1'b0, 1'b1, 2'd2, 16'd0);
        do_start();
        send_bytes(0, PB, 1'b0);
        wait_end("ctrl_error");
        err_on_pp = 1'b0;

        // reset while the first page program is in flight
        exp_head();
        exp_erase(24'hFFFF00);
        pe(8'h06, 24'h0, 1'b0, 1'b1, 1'b0);
        pe(8'h02, 24'hFFFF00, 1'b1, 1'b1, 1'b0);
        do_start();
        send_bytes(0, PB, 1'b0);
        c = 0;
        while (!(mc_trigger && mc_cmd == 8'h02) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("pp_seen_before_reset", {31'h0, (c < 2000)}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset_outs("mid_prog_reset");
        @(negedge clk);
        chk("trace_left_at_reset", exp_q.size(), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("quiet_after_reset", {31'h0, mc_trigger}, 32'h0);

        preload();
        exp_full_run();
        do_start();
        send_bytes(0, 2 * PB, 1'b0);
        wait_end("after_reset");
        check_mem("after_reset");

        repeat (5) @(negedge clk);
        chk("trace_left_at_end", exp_q.size(), 0);
        chk("status_left_at_end", st_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
